sys_bus_tmo: RTL

- System-bus response stage between the CPU-side bus bridge (master) and one register-bank slave, such as the housekeeping block.
- Registers each master request and forwards it to the slave as a one-cycle strobe.
- Waits for the slave's acknowledge and returns the read data, ack and error to the master.
- Ensures the master never hangs: a timeout produces an error response, and timeout events are counted.

---
 rtl/sys_bus_tmo.sv | 105 ++++++++++
 1 files changed

// File: rtl/sys_bus_tmo.sv
// System-bus response stage: registers a master request, strobes the slave once,
// and returns the slave's response. If the slave never answers, a timeout error is returned.
module sys_bus_tmo #(
  parameter int unsigned   AW  = 32,
  parameter int unsigned   DW  = 32,
  parameter int unsigned   TW  = 8,
  parameter logic [TW-1:0] TMO = 8'd255
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [AW-1:0] m_addr_i,
  input  logic [DW-1:0] m_wdata_i,
  input  logic [3:0]    m_sel_i,
  input  logic          m_wen_i,
  input  logic          m_ren_i,
  output logic [DW-1:0] m_rdata_o,
  output logic          m_err_o,
  output logic          m_ack_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  output logic [3:0]    s_sel_o,
  output logic          s_wen_o,
  output logic          s_ren_o,
  input  logic [DW-1:0] s_rdata_i,
  input  logic          s_err_i,
  input  logic          s_ack_i,
  output logic          busy_o,
  output logic [15:0]   tmo_cnt_o
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // The timer holds k-1 in WAIT cycle k, so the last allowed cycle is where it reads TMO-1.
  localparam logic [TW-1:0] TMO_LAST = TMO - 1'b1;

  state_t        state;
  logic [TW-1:0] timer;
  logic          is_read;

  assign busy_o = (state == S_WAIT);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      timer     <= '0;
      is_read   <= 1'b0;
      m_rdata_o <= '0;
      m_err_o   <= 1'b0;
      m_ack_o   <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_sel_o   <= '0;
      s_wen_o   <= 1'b0;
      s_ren_o   <= 1'b0;
      tmo_cnt_o <= '0;
    end else begin
      s_wen_o <= 1'b0;
      s_ren_o <= 1'b0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (m_wen_i && m_ren_i) begin
            m_ack_o   <= 1'b1;
            m_err_o   <= 1'b1;
            m_rdata_o <= '0;
          end else if (m_wen_i || m_ren_i) begin
            s_addr_o  <= m_addr_i;
            s_wdata_o <= m_wdata_i;
            s_sel_o   <= m_sel_i;
            s_wen_o   <= m_wen_i;
            s_ren_o   <= m_ren_i;
            is_read   <= m_ren_i;
            timer     <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Master strobes arriving here are protocol violations and are dropped.
          if (s_ack_i) begin
            m_ack_o   <= 1'b1;
            m_err_o   <= s_err_i;
            m_rdata_o <= is_read ? s_rdata_i : '0;
            state     <= S_IDLE;
          end else if (timer == TMO_LAST) begin
            m_ack_o   <= 1'b1;
            m_err_o   <= 1'b1;
            m_rdata_o <= '0;
            if (tmo_cnt_o != 16'hFFFF) begin
              tmo_cnt_o <= tmo_cnt_o + 16'd1;
            end
            state     <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
